// File: rtl/random_galois_lfsr_param.sv
// ---------------------------------------------------------------------------
// random_galois_lfsr_param
//
// Parametrised right-shift Galois LFSR random source. Each advance applies
// STEPS single-bit shifts to the state and produces a candidate draw. In range
// mode (RANGE > 0) a candidate is accepted only if its low IDX_W bits are below
// RANGE. A rejected candidate bumps a saturating counter and is retried on the
// next enabled cycle. Accepted draws are held on a valid/ready handshake.
// Runtime seed load and all-zero state recovery are also supported.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst_n          in   1       synchronous reset, active low
//   i_enable       in   1       allow advancing while no draw is held
//   i_load         in   1       load i_seed (a seed of 0 becomes 1)
//   i_seed         in   WIDTH   seed value used with i_load
//   i_ready        in   1       consumer takes the held draw
//   o_valid        out  1       a draw is held on the data outputs
//   o_random_data  out  WIDTH   full LFSR state of the accepted draw
//   o_range_data   out  IDX_W   low IDX_W bits of the accepted draw
//   o_reject_cnt   out  16      rejected draws since reset/load (saturating)
//   o_lockup       out  1       one-cycle pulse when an all-zero state is repaired
// ---------------------------------------------------------------------------
module random_galois_lfsr_param #(
  parameter int                WIDTH     = 23,
  parameter logic [WIDTH-1:0]  POLY_MASK = 23'h420000,
  parameter logic [WIDTH-1:0]  SEED      = 23'd65,
  parameter int                STEPS     = 1,
  parameter int unsigned       RANGE     = 0,
  localparam int               IDX_W     = (RANGE > 1) ? $clog2(RANGE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_seed,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_random_data,
  output logic [IDX_W-1:0]   o_range_data,
  output logic [15:0]        o_reject_cnt,
  output logic               o_lockup
);

  typedef enum logic {
    GEN  = 1'b0,
    HOLD = 1'b1
  } fsm_t;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  // An all-zero seed would lock the generator, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_FIX = (SEED == ZERO_W) ? ONE_W : SEED;

  // STEPS single-bit Galois shifts, unrolled into combinational logic.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < STEPS; i++) begin
      v = (v >> 1) ^ (v[0] ? POLY_MASK : ZERO_W);
    end
    return v;
  endfunction

  fsm_t               fsm_r, fsm_nxt_s;
  logic [WIDTH-1:0]   state_r, state_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic [WIDTH-1:0]   data_r, data_nxt_s;
  logic [IDX_W-1:0]   range_r, range_nxt_s;
  logic [15:0]        cnt_r, cnt_nxt_s;
  logic               lockup_r, lockup_nxt_s;

  logic [WIDTH-1:0]   cand_s;
  logic [31:0]        cand_idx_s;
  logic               accept_s;
  logic               advance_s;

  assign cand_s     = lfsr_advance(state_r);
  // Only the low IDX_W bits take part in the range compare.
  assign cand_idx_s = 32'(cand_s[IDX_W-1:0]);
  assign accept_s   = (RANGE == 32'd0) || (cand_idx_s < RANGE);

  // Next-state and next-output logic for the GEN/HOLD handshake machine.
  always_comb begin
    fsm_nxt_s    = fsm_r;
    state_nxt_s  = state_r;
    valid_nxt_s  = valid_r;
    data_nxt_s   = data_r;
    range_nxt_s  = range_r;
    cnt_nxt_s    = cnt_r;
    lockup_nxt_s = 1'b0;
    advance_s    = 1'b0;

    if (i_load) begin
      // Load wins over enable/ready; any held draw is dropped.
      state_nxt_s = (i_seed == ZERO_W) ? ONE_W : i_seed;
      valid_nxt_s = 1'b0;
      cnt_nxt_s   = 16'd0;
      fsm_nxt_s   = GEN;
    end else begin
      // HOLD advances on consumption regardless of i_enable.
      case (fsm_r)
        GEN:     advance_s = i_enable;
        HOLD:    advance_s = i_ready;
        default: advance_s = 1'b0;
      endcase

      if (advance_s) begin
        if (state_r == ZERO_W) begin
          // Zero state can only come from an upset: repair it, produce no draw.
          state_nxt_s  = ONE_W;
          lockup_nxt_s = 1'b1;
          valid_nxt_s  = 1'b0;
          fsm_nxt_s    = GEN;
        end else begin
          state_nxt_s = cand_s;
          if (accept_s) begin
            data_nxt_s  = cand_s;
            range_nxt_s = cand_s[IDX_W-1:0];
            valid_nxt_s = 1'b1;
            fsm_nxt_s   = HOLD;
          end else begin
            valid_nxt_s = 1'b0;
            fsm_nxt_s   = GEN;
            if (cnt_r != 16'hFFFF) begin
              cnt_nxt_s = cnt_r + 16'd1;
            end else begin
              cnt_nxt_s = cnt_r;
            end
          end
        end
      end else begin
        fsm_nxt_s = fsm_r;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r    <= GEN;
      state_r  <= SEED_FIX;
      valid_r  <= 1'b0;
      data_r   <= ZERO_W;
      range_r  <= {IDX_W{1'b0}};
      cnt_r    <= 16'd0;
      lockup_r <= 1'b0;
    end else begin
      fsm_r    <= fsm_nxt_s;
      state_r  <= state_nxt_s;
      valid_r  <= valid_nxt_s;
      data_r   <= data_nxt_s;
      range_r  <= range_nxt_s;
      cnt_r    <= cnt_nxt_s;
      lockup_r <= lockup_nxt_s;
    end
  end

  assign o_valid       = valid_r;
  assign o_random_data = data_r;
  assign o_range_data  = range_r;
  assign o_reject_cnt  = cnt_r;
  assign o_lockup      = lockup_r;

endmodule

// File: tb/tb_random_galois_lfsr_param.sv
// ---------------------------------------------------------------------------
// tb_random_galois_lfsr_param
//
// Drives three generator instances from one shared stimulus:
//   A: defaults (STEPS=1, RANGE=0)   B: STEPS=2   C: RANGE=3
// A transaction-level reference model per instance predicts every output
// after each clock edge. Directed scenarios add constant expectations.
// ---------------------------------------------------------------------------
module tb_random_galois_lfsr_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, ld, rdy;
  logic [22:0] seed;

  logic        va, vb, vc;
  logic [22:0] da, db, dc;
  logic        ra, rb;
  logic [1:0]  rc;
  logic [15:0] ca, cb, cc;
  logic        la, lb, lc;

  random_galois_lfsr_param dut_a (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_load(ld), .i_seed(seed), .i_ready(rdy),
    .o_valid(va), .o_random_data(da), .o_range_data(ra), .o_reject_cnt(ca), .o_lockup(la));

  random_galois_lfsr_param #(.STEPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_load(ld), .i_seed(seed), .i_ready(rdy),
    .o_valid(vb), .o_random_data(db), .o_range_data(rb), .o_reject_cnt(cb), .o_lockup(lb));

  random_galois_lfsr_param #(.RANGE(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_load(ld), .i_seed(seed), .i_ready(rdy),
    .o_valid(vc), .o_random_data(dc), .o_range_data(rc), .o_reject_cnt(cc), .o_lockup(lc));

  int n_err = 0;
  int n_chk = 0;

  // Reference model state per instance
  int unsigned m_state [3];
  int unsigned m_data  [3];
  int unsigned m_cnt   [3];
  bit          m_valid [3];
  bit          m_lock  [3];
  int unsigned m_steps [3] = '{1, 2, 1};
  int unsigned m_range [3] = '{0, 0, 3};
  int unsigned m_mod   [3] = '{2, 2, 4};   // 2**IDX_W

  // n Galois shifts with the x^23+x^18+1 feedback mask, plain integer math
  function automatic int unsigned lfsr_next(int unsigned s, int unsigned n);
    int unsigned v;
    v = s;
    for (int i = 0; i < n; i++) begin
      if (v % 2 == 1) v = (v / 2) ^ 32'h420000;
      else            v = v / 2;
    end
    return v;
  endfunction

  // Predict the effect of the coming clock edge for every instance
  task automatic model_step();
    int unsigned c;
    bit adv;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_state[k] = 65; m_valid[k] = 0; m_data[k] = 0; m_cnt[k] = 0; m_lock[k] = 0;
      end else if (ld) begin
        m_state[k] = (seed == 23'd0) ? 1 : int'(seed);
        m_valid[k] = 0; m_cnt[k] = 0; m_lock[k] = 0;
      end else begin
        m_lock[k] = 0;
        adv = m_valid[k] ? rdy : en;
        if (adv) begin
          if (m_state[k] == 0) begin
            m_state[k] = 1; m_lock[k] = 1; m_valid[k] = 0;
          end else begin
            c = lfsr_next(m_state[k], m_steps[k]);
            m_state[k] = c;
            if (m_range[k] == 0 || (c % m_mod[k]) < m_range[k]) begin
              m_data[k] = c; m_valid[k] = 1;
            end else begin
              m_valid[k] = 0;
              if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] gv [3];
    logic [31:0] gd [3];
    logic [31:0] gr [3];
    logic [31:0] gc [3];
    logic [31:0] gl [3];
    gv[0] = 32'(va); gv[1] = 32'(vb); gv[2] = 32'(vc);
    gd[0] = 32'(da); gd[1] = 32'(db); gd[2] = 32'(dc);
    gr[0] = 32'(ra); gr[1] = 32'(rb); gr[2] = 32'(rc);
    gc[0] = 32'(ca); gc[1] = 32'(cb); gc[2] = 32'(cc);
    gl[0] = 32'(la); gl[1] = 32'(lb); gl[2] = 32'(lc);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("m%0d_valid", k),  gv[k], 32'(m_valid[k]));
      chk($sformatf("m%0d_data", k),   gd[k], m_data[k]);
      chk($sformatf("m%0d_range", k),  gr[k], m_data[k] % m_mod[k]);
      chk($sformatf("m%0d_cnt", k),    gc[k], m_cnt[k]);
      chk($sformatf("m%0d_lockup", k), gl[k], 32'(m_lock[k]));
    end
  endtask

  // One clock: predict, let the edge happen, sample 1 time unit later
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; rdy = 1'b0; seed = 23'd0;
    tick();
    tick();
    chk("reset_valid", 32'(va), 32'd0);
    chk("reset_data",  32'(da), 32'd0);
    chk("reset_cnt",   32'(cc), 32'd0);

    // T1 / T2: seed 1, continuous enable and ready
    rst_n = 1'b1; ld = 1'b1; seed = 23'd1;
    tick();
    chk("t1_load_valid", 32'(va), 32'd0);
    ld = 1'b0; en = 1'b1; rdy = 1'b1;
    tick();
    chk("t1_first_valid", 32'(va), 32'd1);
    chk("t1_first_data",  32'(da), 32'h420000);
    chk("t2_steps2_data", 32'(db), 32'h210000);
    chk("t2_steps2_range", 32'(rb), 32'd0);
    tick();
    chk("t1_second_data", 32'(da), 32'h210000);

    // T4: held draw stays put while i_ready is low, whatever i_enable does
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = i[0];
      tick();
      chk("t4_hold_data",  32'(da), 32'h210000);
      chk("t4_hold_valid", 32'(va), 32'd1);
    end
    rdy = 1'b1; en = 1'b0;
    tick();
    chk("t4_resume_data", 32'(da), 32'h108000);

    // T5: load seed 0 while holding a draw
    rdy = 1'b0; ld = 1'b1; seed = 23'd0;
    tick();
    chk("t5_valid", 32'(va), 32'd0);
    chk("t5_cnt",   32'(ca), 32'd0);
    ld = 1'b0; en = 1'b1; rdy = 1'b1;
    tick();
    chk("t5_seed1_data", 32'(da), 32'h420000);

    // T3: range mode, seed 6 -> 3 rejected, then 0x420001 accepted
    ld = 1'b1; seed = 23'd6;
    tick();
    ld = 1'b0; en = 1'b1; rdy = 1'b1;
    tick();
    chk("t3_reject_valid", 32'(vc), 32'd0);
    chk("t3_reject_cnt",   32'(cc), 32'd1);
    tick();
    chk("t3_accept_valid", 32'(vc), 32'd1);
    chk("t3_accept_data",  32'(dc), 32'h420001);
    chk("t3_accept_range", 32'(rc), 32'd1);

    // T6: upset to all-zero state on instance A, held across one edge
    ld = 1'b1; seed = 23'd1;
    tick();
    ld = 1'b0; en = 1'b1; rdy = 1'b0;
    force dut_a.state_r = 23'd0;
    m_state[0] = 0;
    tick();
    chk("t6_lockup_pulse", 32'(la), 32'd1);
    chk("t6_lockup_valid", 32'(va), 32'd0);
    release dut_a.state_r;
    ld = 1'b1; seed = 23'd1; en = 1'b0;
    tick();
    chk("t6_lockup_clear", 32'(la), 32'd0);
    ld = 1'b0; en = 1'b1;
    tick();
    chk("t6_after_data", 32'(da), 32'h420000);
    // reset in the middle of HOLD
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 32'(va), 32'd0);
    chk("t6_rst_data",  32'(da), 32'd0);
    rst_n = 1'b1; ld = 1'b0;
    tick();
    chk("t6_rst_seed_draw", 32'(da), 32'(lfsr_next(65, 1)));

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      rdy   = $urandom_range(0, 1) == 1;
      ld    = ($urandom_range(0, 39) == 0);
      seed  = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
